pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-look-ahead adder/subtractor; generalises the team's fixed 8-bit adders to WIDTH bits.
- Operand is split into GROUP-bit CLA slices; one slice per pipeline stage, carry registered between stages.
- Valid/ready handshake on input and output, so it drops into streaming datapaths (accumulators, ALU pipes) with backpressure.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of GROUP and at least GROUP.
- GROUP, 4, bits per CLA slice. NUM_STAGES = WIDTH/GROUP, which is also the latency in cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a, b, cin, sub are valid
- in_ready  out  1  block accepts the operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in, used when sub=0
- sub  in  1  1: s = a - b (cin ignored); 0: s = a + b + cin
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- s  out  WIDTH  sum/difference
- cout  out  1  carry-out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow
- zero  out  1  s == 0

Behaviour:
- Reset (async, rst_n=0): all stage valid bits = 0, all data/carry registers = 0; out_valid=0, s=0, cout=0, ovf=0, zero=1 (s=0). Reset mid-operation discards every in-flight result with no partial output. in_ready becomes 1 in the first cycle after release.
- Operand preparation at input: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..NUM_STAGES-1) adds slice k of a and b_eff with the carry registered by stage k-1 (c0 for k=0), using a GROUP-bit CLA.
- Registers per stage: sum slice k, carry out, and the not-yet-consumed upper slices of a and b_eff (skew registers).
- Lower finished slices shift along with the data, so each stage adds only a GROUP-bit CLA and a register delay.
- Advance enable: en = !out_valid || out_ready. All stages shift together when en=1 and hold entirely when en=0 (global stall; bubbles propagate as valid=0).
- Handshake:
  - in_ready = en.
  - Transfer-in occurs when in_valid && in_ready.
  - Transfer-out occurs when out_valid && out_ready.
  - Both may occur in the same cycle at full throughput (1 result per cycle).
- Latency: a transfer-in at cycle t gives out_valid=1 at cycle t+NUM_STAGES if no stall occurs. Each stall cycle adds one cycle.
- Output stability: while out_valid=1 && out_ready=0, s, cout, ovf and zero hold constant.
- Output flags:
  - cout = carry out of the last stage.
  - ovf = carry into MSB XOR cout. MSB carry-in is computed in the last stage and registered with the result.
  - zero is a registered compare of the final s.
- Width rules:
  - The result is exactly WIDTH bits; wrap-around is modulo 2^WIDTH and is reported via cout.
  - WIDTH == GROUP degenerates to a single-stage registered CLA with latency 1.
- When in_valid=0 and en=1, a bubble enters the pipeline. Data registers may update, but their valid bits are 0.

Decomposition:
- Shared package adder_pkg:
  - default WIDTH/GROUP constants;
  - a function computing NUM_STAGES;
  - an elaboration-time check that WIDTH % GROUP == 0.
- Sub-module cla_group:
  - combinational GROUP-bit CLA;
  - inputs x, y, ci; outputs sum, co, and c_msb (carry into the top bit, needed for ovf);
  - instantiated once per stage in a generate loop.
- Top level holds the stage registers, skew registers and handshake logic.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, s=0, zero=1. After release, 0x0005+0x0003 cin=0 -> s=0x0008, cout=0, ovf=0, out_valid exactly 4 cycles after accept.
- Carry chain across all groups: 0xFFFF+0x0001 cin=0 -> s=0x0000, cout=1, zero=1, ovf=0. Then 0xA5A5+0x5A5A cin=1 -> s=0x0000, cout=1.
- Signed overflow and subtract:
  - 0x7FFF+0x0001 -> s=0x8000, ovf=1, cout=0;
  - sub=1, 0x0003-0x0005 -> s=0xFFFE, cout=0;
  - sub=1, 0x8000-0x0001 -> s=0x7FFF, ovf=1, cout=1.
- Throughput: 8 back-to-back inputs (a=i, b=i*3, cin=i[0]) with out_ready=1 -> 8 consecutive out_valid cycles, in order, all sums correct.
- Backpressure: out_ready=0 for 5 cycles with the pipe full -> in_ready=0, outputs held constant, no loss or duplication. Release -> remaining results drain in order.
- Reset mid-stream: assert rst_n=0 with 3 results in flight -> out_valid=0 immediately (async). No stale result appears after release. WIDTH=8/GROUP=8 build -> latency 1, 0xFF+0xFF cin=1 -> s=0xFF, cout=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and geometry helpers for the pipelined CLA adder family.
package adder_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefGroup = 4;

  // One CLA slice per stage, so this is also the latency in cycles.
  function automatic int unsigned num_stages(int unsigned width, int unsigned group);
    return width / group;
  endfunction

  function automatic bit geometry_ok(int unsigned width, int unsigned group);
    return (group != 0) && (width >= group) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result valid-ready bundle for the pipelined CLA adder.
interface pipelined_cla_adder_if
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );

endinterface

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-look-ahead slice; also exports the carry into its top bit.
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] x,
  input  logic [GROUP-1:0] y,
  input  logic             ci,
  output logic [GROUP-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;
  logic             prod;

  assign g = x & y;
  assign p = x ^ y;

  // Flattened look-ahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci
  always_comb begin
    c    = '0;
    prod = 1'b0;
    c[0] = ci;
    for (int i = 0; i < int'(GROUP); i++) begin
      c[i+1] = g[i];
      prod   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prod & g[j]);
        prod   = prod & p[j];
      end
      c[i+1] = c[i+1] | (prod & ci);
    end
  end

  assign sum   = p ^ c[GROUP-1:0];
  assign co    = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit adder/subtractor, one GROUP-bit CLA slice per pipeline stage, valid/ready on both sides.
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned GROUP = DefGroup
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_cla_adder_if.slave bus
);

  localparam int unsigned NumStages = num_stages(WIDTH, GROUP);
  localparam int unsigned Last      = NumStages - 1;

  if (!geometry_ok(WIDTH, GROUP)) begin : g_bad_geometry
    $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  logic                 en;
  logic [WIDTH-1:0]     a_src   [NumStages];
  logic [WIDTH-1:0]     b_src   [NumStages];
  logic [WIDTH-1:0]     s_src   [NumStages];
  logic [NumStages-1:0] c_src;
  logic [NumStages-1:0] v_src;
  logic [GROUP-1:0]     grp_sum [NumStages];
  logic [NumStages-1:0] grp_co;
  logic [NumStages-1:0] grp_cmsb;

  logic [WIDTH-1:0]     a_q   [NumStages];
  logic [WIDTH-1:0]     a_d   [NumStages];
  logic [WIDTH-1:0]     b_q   [NumStages];
  logic [WIDTH-1:0]     b_d   [NumStages];
  logic [WIDTH-1:0]     sum_q [NumStages];
  logic [WIDTH-1:0]     sum_d [NumStages];
  logic [NumStages-1:0] c_q, c_d;
  logic [NumStages-1:0] v_q, v_d;
  logic                 ovf_q, ovf_d;
  logic                 zero_q, zero_d;

  // Stage 0 sees the prepared operands; stage k sees what stage k-1 registered.
  always_comb begin
    a_src[0] = bus.a;
    b_src[0] = bus.sub ? ~bus.b : bus.b;
    s_src[0] = '0;
    c_src    = '0;
    v_src    = '0;
    c_src[0] = bus.sub | bus.cin;
    v_src[0] = bus.in_valid;
    for (int k = 1; k < int'(NumStages); k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = sum_q[k-1];
      c_src[k] = c_q[k-1];
      v_src[k] = v_q[k-1];
    end
  end

  for (genvar k = 0; k < int'(NumStages); k++) begin : g_stage
    cla_group #(
      .GROUP (GROUP)
    ) u_cla (
      .x     (a_src[k][k*GROUP +: GROUP]),
      .y     (b_src[k][k*GROUP +: GROUP]),
      .ci    (c_src[k]),
      .sum   (grp_sum[k]),
      .co    (grp_co[k]),
      .c_msb (grp_cmsb[k])
    );
  end

  assign en = !v_q[Last] || bus.out_ready;

  // Global stall: every stage either shifts or holds together.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sum_d  = sum_q;
    c_d    = c_q;
    v_d    = v_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (en) begin
      for (int k = 0; k < int'(NumStages); k++) begin
        a_d[k]                     = a_src[k];
        b_d[k]                     = b_src[k];
        sum_d[k]                   = s_src[k];
        sum_d[k][k*GROUP +: GROUP] = grp_sum[k];
        c_d[k]                     = grp_co[k];
        v_d[k]                     = v_src[k];
      end
      ovf_d  = grp_cmsb[Last] ^ grp_co[Last];
      zero_d = (sum_d[Last] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NumStages); k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      c_q    <= '0;
      v_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      sum_q  <= sum_d;
      c_q    <= c_d;
      v_q    <= v_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = v_q[Last];
  assign bus.s         = sum_q[Last];
  assign bus.cout      = c_q[Last];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder: 16/4 build plus a degenerate 8/8 build.
module tb_pipelined_cla_adder;

  localparam int unsigned NS = 4;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[9];

  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(16)) bus ();
  pipelined_cla_adder_if #(.WIDTH(8))  bus8 ();

  pipelined_cla_adder #(
    .WIDTH (16),
    .GROUP (4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pipelined_cla_adder #(
    .WIDTH (8),
    .GROUP (8)
  ) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_single(input vec_t v);
    int lat;
    bit got;
    @(negedge clk);
    bus.a         = v.a;
    bus.b         = v.b;
    bus.cin       = v.cin;
    bus.sub       = v.sub;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk({v.name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid) got = 1'b1;
    end
    chk({v.name, "_latency"}, 32'(lat), 32'(NS));
    chk({v.name, "_s"},    32'(bus.s),    32'(v.s));
    chk({v.name, "_cout"}, 32'(bus.cout), 32'(v.cout));
    chk({v.name, "_ovf"},  32'(bus.ovf),  32'(v.ovf));
    chk({v.name, "_zero"}, 32'(bus.zero), 32'(v.zero));
  endtask

  task automatic send8(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    bit got;
    @(negedge clk);
    bus8.a        = a;
    bus8.b        = b;
    bus8.cin      = cin;
    bus8.sub      = 1'b0;
    bus8.in_valid = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus8.in_valid = 1'b0;
      #1;
      if (bus8.out_valid) got = 1'b1;
    end
    chk({name, "_latency"}, 32'(lat), 32'd1);
    chk({name, "_s"},    32'(bus8.s),    32'(es));
    chk({name, "_cout"}, 32'(bus8.cout), 32'(ec));
    chk({name, "_ovf"},  32'(bus8.ovf),  32'(eo));
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tx;
    int rx;
    int first;
    int last;
    int stall;
    int seen;

    vecs[0] = '{"add_small",   16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"carry_all",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{"alt_cin",     16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{"pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"sub_neg",     16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{"sub_eq",      16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{"neg_ovf",     16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{"sub_cin_ign", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0};

    bus.in_valid   = 1'b1;
    bus.a          = 16'h1234;
    bus.b          = 16'h0001;
    bus.cin        = 1'b0;
    bus.sub        = 1'b0;
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.cin       = 1'b0;
    bus8.sub       = 1'b0;
    bus8.out_ready = 1'b1;

    // Reset held with in_valid asserted: nothing may come out.
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_s",         32'(bus.s),         32'd0);
    chk("reset_zero",      32'(bus.zero),      32'd1);
    chk("reset_cout",      32'(bus.cout),      32'd0);
    chk("reset_ovf",       32'(bus.ovf),       32'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) send_single(vecs[i]);

    // Throughput: 8 back-to-back operands, expected sum i + 3i + i[0].
    tx = 0; rx = 0; first = -1; last = -1;
    @(negedge clk);
    for (int cyc = 0; cyc < 30; cyc++) begin
      bus.out_ready = 1'b1;
      bus.sub       = 1'b0;
      bus.in_valid  = (tx < 8);
      bus.a         = 16'(tx);
      bus.b         = 16'(tx * 3);
      bus.cin       = tx[0];
      #1;
      if (bus.out_valid) begin
        chk($sformatf("tput_s%0d", rx), 32'(bus.s), 32'(4 * rx + (rx % 2)));
        if (first < 0) first = cyc;
        last = cyc;
        rx++;
      end
      if (bus.in_valid && bus.in_ready) tx++;
      @(negedge clk);
    end
    chk("tput_count", 32'(rx), 32'd8);
    chk("tput_first", 32'(first), 32'(NS));
    chk("tput_span",  32'(last - first), 32'd7);

    // Backpressure: downstream stalls until cycle 9, six operands 0x1000+j + j.
    tx = 0; rx = 0; stall = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.out_ready = (cyc >= 9);
      bus.in_valid  = (tx < 6);
      bus.a         = 16'h1000 + 16'(tx);
      bus.b         = 16'(tx);
      bus.cin       = 1'b0;
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        stall++;
        chk($sformatf("bp_in_ready_c%0d", cyc), 32'(bus.in_ready), 32'd0);
        chk($sformatf("bp_hold_s_c%0d", cyc), 32'(bus.s), 32'h1000 + 32'(2 * rx));
        chk($sformatf("bp_hold_cout_c%0d", cyc), 32'(bus.cout), 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("bp_s%0d", rx), 32'(bus.s), 32'h1000 + 32'(2 * rx));
        rx++;
      end
      if (bus.in_valid && bus.in_ready) tx++;
      @(negedge clk);
    end
    chk("bp_count", 32'(rx), 32'd6);
    chk("bp_stall_cycles", 32'(stall), 32'd5);

    // Reset mid-stream with three results in flight.
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      bus.in_valid = (cyc < 3);
      bus.a        = 16'h0100 + 16'(cyc);
      bus.b        = 16'h0001;
      #1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    chk("mr_pre_valid", 32'(bus.out_valid), 32'd1);
    chk("mr_pre_s",     32'(bus.s),         32'h0101);
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_s",         32'(bus.s),         32'd0);
    chk("mr_zero",      32'(bus.zero),      32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("mr_no_stale", 32'(seen), 32'd0);

    // Degenerate single-stage build.
    send8("w8_ff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    send8("w8_ovf",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
